state_ctrl: RTL and testbench

STATE_CTRL -- requirements
Module: state_ctrl

---
 rtl/state_ctrl.sv | 88 ++++++++
 tb/tb_state_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/state_ctrl.sv
// Parent controller that detects two consecutive '1's, releases a sub-FSM,
// and reclaims control on sub-FSM completion or after TIMEOUT cycles.
module state_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       state_out,
    input  logic       out1,
    output logic       state_select,
    output logic       out_pass,
    output logic       frame_done,
    output logic       timeout,
    output logic [7:0] det_count,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        P0    = 2'b00,
        P1    = 2'b01,
        CHILD = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] det_q, det_d;
    logic       timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= P0;
            timer_q   <= 8'd0;
            det_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            det_q     <= det_d;
            timeout_q <= timeout_d;
        end
    end

    // Timer defaults to 0 so it is cleared on every CHILD entry and held outside CHILD.
    always_comb begin
        state_d   = state_q;
        timer_d   = 8'd0;
        det_d     = det_q;
        timeout_d = 1'b0;
        case (state_q)
            P0: begin
                if (in) state_d = P1;
            end
            P1: begin
                state_d = in ? CHILD : P0;
            end
            CHILD: begin
                if (state_out) begin
                    state_d = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = P0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DONE: begin
                state_d = P0;
                det_d   = (det_q == 8'hFF) ? det_q : det_q + 8'd1;
            end
            default: begin
                state_d = P0;
            end
        endcase
    end

    // All outputs decode registered state only, except out_pass which gates out1.
    assign state_select = (state_q != CHILD);
    assign out_pass     = (state_q == CHILD) & out1;
    assign frame_done   = (state_q == DONE);
    assign timeout      = timeout_q;
    assign det_count    = det_q;
    assign mode         = state_q;

endmodule

// File: tb/tb_state_ctrl.sv
// Randomized and directed stimulus for state_ctrl, checked against a
// behavioural model through an expected-output queue.
module tb_state_ctrl;

    localparam int unsigned TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic       in_s;
    logic       state_out;
    logic       out1;
    logic       state_select;
    logic       out_pass;
    logic       frame_done;
    logic       timeout;
    logic [7:0] det_count;
    logic [1:0] mode;

    state_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in_s),
        .state_out    (state_out),
        .out1         (out1),
        .state_select (state_select),
        .out_pass     (out_pass),
        .frame_done   (frame_done),
        .timeout      (timeout),
        .det_count    (det_count),
        .mode         (mode)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mode, state_select, out_pass, frame_done, timeout, det_count}
    logic [13:0] exp_q[$];
    int vectors;
    int miscompares;

    // reference model: what the controller is doing, in plain terms
    bit m_armed;      // one '1' seen while idle
    bit m_in_child;   // sub-FSM released
    int m_age;        // cycles already spent with the sub-FSM released
    bit m_done;       // completion cycle
    bit m_tout;       // timeout just happened
    int m_completions;

    function automatic logic [13:0] model_outputs(input bit o1);
        logic [1:0] md;
        logic [7:0] cnt;
        md  = m_done ? 2'd3 : (m_in_child ? 2'd2 : (m_armed ? 2'd1 : 2'd0));
        cnt = 8'(m_completions);
        return {md, !m_in_child, m_in_child && o1, m_done, m_tout, cnt};
    endfunction

    task automatic model_edge(input bit r, input bit i, input bit s);
        if (r) begin
            m_armed = 0; m_in_child = 0; m_age = 0; m_done = 0; m_tout = 0;
            m_completions = 0;
        end else if (m_done) begin
            m_done = 0;
            m_tout = 0;
            if (m_completions < 255) m_completions++;
        end else if (m_in_child) begin
            m_tout = 0;
            if (s) begin
                m_in_child = 0;
                m_done = 1;
            end else if (m_age + 1 == TIMEOUT) begin
                m_in_child = 0;
                m_tout = 1;
            end else begin
                m_age++;
            end
        end else if (m_armed) begin
            m_tout = 0;
            m_armed = 0;
            if (i) begin
                m_in_child = 1;
                m_age = 0;
            end
        end else begin
            m_tout = 0;
            m_armed = i;
        end
    endtask

    // driver: inputs change on the falling edge, expectation queued for the next rise
    task automatic cycle(input bit r, input bit i, input bit s, input bit o1);
        @(negedge clk);
        rst = r; in_s = i; state_out = s; out1 = o1;
        model_edge(r, i, s);
        exp_q.push_back(model_outputs(o1));
    endtask

    task automatic enter_child();
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
    endtask

    // monitor / scoreboard
    always @(posedge clk) begin
        logic [13:0] exp_v;
        logic [13:0] act_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {mode, state_select, out_pass, frame_done, timeout, det_count};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs @%0t: got mode=%b sel=%b pass=%b done=%b tout=%b cnt=%0d, need mode=%b sel=%b pass=%b done=%b tout=%b cnt=%0d",
                         $time, act_v[13:12], act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                         exp_v[13:12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        m_armed = 0; m_in_child = 0; m_age = 0; m_done = 0; m_tout = 0; m_completions = 0;
        rst = 1'b1; in_s = 1'b1; state_out = 1'b0; out1 = 1'b0;

        // reset held with in=1
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 1);

        // entry then completion on the third released cycle
        enter_child();
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // full timeout
        enter_child();
        for (int k = 0; k < TIMEOUT; k++) cycle(0, 0, 0, 32'($urandom_range(0, 1)));
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // completion colliding with the last allowed cycle
        enter_child();
        for (int k = 0; k < TIMEOUT - 1; k++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // saturation of the completion count
        for (int k = 0; k < 258; k++) begin
            enter_child();
            cycle(0, 0, 1, 1);
            cycle(0, 1, 1, 1);
        end
        cycle(0, 0, 0, 0);

        // reset in the middle of a released period
        enter_child();
        cycle(0, 1, 0, 1);
        cycle(0, 1, 0, 1);
        cycle(1, 1, 1, 1);
        cycle(0, 0, 0, 1);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0,
                  32'($urandom_range(0, 1)));
        end

        // drain the scoreboard with a bound
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, need 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
